otter_wb_arbiter: RTL and testbench

OTTER_WB_ARBITER -- requirements
Module: otter_wb_arbiter

---
 rtl/otter_wb_pkg.sv | 17 +
 rtl/otter_wb_arbiter_if.sv | 36 +++
 rtl/otter_wb_fifo.sv | 57 +++++
 rtl/otter_wb_arbiter.sv | 130 +++++++++++++
 tb/tb_otter_wb_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/otter_wb_pkg.sv
// Shared types and constants for the writeback arbiter and its result buffer.
package otter_wb_pkg;

  localparam int unsigned WB_FIFO_DEPTH = 2;
  localparam int unsigned WB_STARVE_MAX = 3;

  typedef enum logic [0:0] {
    ARB_ALU,
    ARB_DRAIN
  } arb_state_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/otter_wb_arbiter_if.sv
// Pipeline-side bundle for the writeback arbiter: ALU/multi-cycle results,
// register file write port and scoreboard lookups.
interface otter_wb_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;

  logic        mc_valid;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        mc_ready;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic        hazard;
  logic        proto_err;

  modport master (
    output alu_valid, alu_rd, alu_data, mc_valid, mc_rd, mc_data,
    output issue_valid, issue_rd, chk_rs1, chk_rs2,
    input  alu_stall, mc_ready, rf_we, rf_waddr, rf_wdata, hazard, proto_err
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mc_valid, mc_rd, mc_data,
    input  issue_valid, issue_rd, chk_rs1, chk_rs2,
    output alu_stall, mc_ready, rf_we, rf_waddr, rf_wdata, hazard, proto_err
  );
endinterface

// File: rtl/otter_wb_fifo.sv
// Small in-order buffer for multi-cycle results awaiting a writeback slot.
module otter_wb_fifo
  import otter_wb_pkg::*;
#(
  parameter int unsigned Depth = WB_FIFO_DEPTH,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            push,
  input  logic            pop,
  input  wb_entry_t       wdata,
  output wb_entry_t       rdata,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  wb_entry_t       mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/otter_wb_arbiter.sv
// Writeback arbiter: ALU results take priority, buffered multi-cycle results are
// drained on idle slots or forcibly after starvation. Scoreboard: OTTER_WB_SCOREBOARD_EN.
module otter_wb_arbiter
  import otter_wb_pkg::*;
(
  input logic               clock,
  input logic               reset_n,
  otter_wb_arbiter_if.slave bus
);

  localparam int unsigned CntW = $clog2(WB_FIFO_DEPTH + 1);
  localparam int unsigned NxtW = CntW + 1;

  arb_state_t      state_q;
  logic [1:0]      starve_q;
  logic            mc_ready_q, proto_err_q;
  logic            rf_we_q;
  logic [4:0]      rf_waddr_q;
  logic [31:0]     rf_wdata_q;

  wb_entry_t       head, mc_entry;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic            alu_win, fifo_pop, mc_push, mc_ready_d;
  logic [NxtW-1:0] cnt_nxt;

  assign mc_entry = '{rd: bus.mc_rd, data: bus.mc_data};
  assign mc_push  = bus.mc_valid && mc_ready_q;

  otter_wb_fifo #(
    .Depth(WB_FIFO_DEPTH)
  ) u_fifo (
    .clock  (clock),
    .reset_n(reset_n),
    .push   (mc_push),
    .pop    (fifo_pop),
    .wdata  (mc_entry),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // A drain cycle always takes the FIFO head, even if the ALU ignores the stall.
  always_comb begin
    alu_win  = 1'b0;
    fifo_pop = 1'b0;
    if (state_q == ARB_DRAIN) fifo_pop = !fifo_empty;
    else if (bus.alu_valid)   alu_win  = 1'b1;
    else                      fifo_pop = !fifo_empty;
  end

  assign cnt_nxt    = {1'b0, fifo_count} + NxtW'(mc_push) - NxtW'(fifo_pop);
  assign mc_ready_d = (cnt_nxt < NxtW'(WB_FIFO_DEPTH));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ARB_ALU;
      starve_q    <= 2'd0;
      mc_ready_q  <= 1'b0;
      proto_err_q <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= 5'd0;
      rf_wdata_q  <= 32'd0;
    end else begin
      mc_ready_q <= mc_ready_d;
      rf_we_q    <= 1'b0;
      if (alu_win) begin
        rf_we_q    <= |bus.alu_rd;
        rf_waddr_q <= bus.alu_rd;
        rf_wdata_q <= bus.alu_data;
      end else if (fifo_pop) begin
        rf_we_q    <= |head.rd;
        rf_waddr_q <= head.rd;
        rf_wdata_q <= head.data;
      end
      case (state_q)
        ARB_ALU: begin
          if (fifo_empty || fifo_pop) begin
            starve_q <= 2'd0;
          end else if (alu_win) begin
            if (starve_q == 2'(WB_STARVE_MAX)) begin
              state_q  <= ARB_DRAIN;
              starve_q <= 2'd0;
            end else begin
              starve_q <= starve_q + 2'd1;
            end
          end
        end
        ARB_DRAIN: begin
          state_q  <= ARB_ALU;
          starve_q <= 2'd0;
          if (bus.alu_valid) proto_err_q <= 1'b1;
        end
        default: state_q <= ARB_ALU;
      endcase
    end
  end

  assign bus.alu_stall = (state_q == ARB_DRAIN);
  assign bus.mc_ready  = mc_ready_q;
  assign bus.proto_err = proto_err_q;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;

`ifdef OTTER_WB_SCOREBOARD_EN
  logic [31:0] busy_q, busy_d;

  // Issue is applied after the writeback clear so a same-cycle re-issue stays busy.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q) busy_d[rf_waddr_q] = 1'b0;
    if (bus.issue_valid && (bus.issue_rd != 5'd0)) busy_d[bus.issue_rd] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) busy_q <= 32'd0;
    else          busy_q <= busy_d;
  end

  assign bus.hazard = ((bus.chk_rs1 != 5'd0) && busy_q[bus.chk_rs1]) ||
                      ((bus.chk_rs2 != 5'd0) && busy_q[bus.chk_rs2]);
`else
  logic unused_sb;
  assign unused_sb  = ^{bus.issue_valid, bus.issue_rd, bus.chk_rs1, bus.chk_rs2};
  assign bus.hazard = 1'b0;
`endif

endmodule

// File: tb/tb_otter_wb_arbiter.sv
// Directed bench for otter_wb_arbiter; hazard expectations follow OTTER_WB_SCOREBOARD_EN.
module tb_otter_wb_arbiter;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  int   checks  = 0;
  int   passed  = 0;

`ifdef OTTER_WB_SCOREBOARD_EN
  localparam logic SbEn = 1'b1;
`else
  localparam logic SbEn = 1'b0;
`endif

  otter_wb_arbiter_if bus ();

  otter_wb_arbiter dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = 5'd0;
    bus.alu_data    = 32'd0;
    bus.mc_valid    = 1'b0;
    bus.mc_rd       = 5'd0;
    bus.mc_data     = 32'd0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = 5'd0;
    bus.chk_rs1     = 5'd0;
    bus.chk_rs2     = 5'd0;
  endtask

  task automatic test_reset();
    idle();
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.rf_we !== 1'b0) $display("FAIL rst_we: got %b want 0", bus.rf_we); else passed++;
    checks++; if (bus.rf_waddr !== 5'd0) $display("FAIL rst_waddr: got %h want 0", bus.rf_waddr); else passed++;
    checks++; if (bus.rf_wdata !== 32'd0) $display("FAIL rst_wdata: got %h want 0", bus.rf_wdata); else passed++;
    checks++; if (bus.mc_ready !== 1'b0) $display("FAIL rst_mc_ready: got %b want 0", bus.mc_ready); else passed++;
    checks++; if (bus.alu_stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", bus.alu_stall); else passed++;
    checks++; if (bus.proto_err !== 1'b0) $display("FAIL rst_proto: got %b want 0", bus.proto_err); else passed++;
    checks++; if (bus.hazard !== 1'b0) $display("FAIL rst_hazard: got %b want 0", bus.hazard); else passed++;
    tick();
    checks++; if (bus.mc_ready !== 1'b0) $display("FAIL rst_ready_held: got %b want 0", bus.mc_ready); else passed++;
    reset_n = 1'b1;
    #1;
    checks++; if (bus.mc_ready !== 1'b0) $display("FAIL rst_ready_pre_edge: got %b want 0", bus.mc_ready); else passed++;
    tick();
    checks++; if (bus.mc_ready !== 1'b1) $display("FAIL rst_ready_rise: got %b want 1", bus.mc_ready); else passed++;
  endtask

  task automatic test_alu_single();
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    tick();
    checks++; if (bus.rf_we !== 1'b1) $display("FAIL alu_we: got %b want 1", bus.rf_we); else passed++;
    checks++; if (bus.rf_waddr !== 5'd5) $display("FAIL alu_waddr: got %0d want 5", bus.rf_waddr); else passed++;
    checks++; if (bus.rf_wdata !== 32'hDEADBEEF) $display("FAIL alu_wdata: got %h want deadbeef", bus.rf_wdata); else passed++;
    bus.alu_rd = 5'd0; bus.alu_data = 32'h1234;
    tick();
    checks++; if (bus.rf_we !== 1'b0) $display("FAIL alu_rd0_we: got %b want 0", bus.rf_we); else passed++;
    idle();
    tick();
    checks++; if (bus.rf_we !== 1'b0) $display("FAIL alu_idle_we: got %b want 0", bus.rf_we); else passed++;
  endtask

  task automatic test_mc_path();
    idle();
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd6; bus.mc_data = 32'h0000600D;
    tick();
    checks++; if (bus.rf_we !== 1'b0) $display("FAIL mc_push_we: got %b want 0", bus.rf_we); else passed++;
    checks++; if (bus.mc_ready !== 1'b1) $display("FAIL mc_ready_one: got %b want 1", bus.mc_ready); else passed++;
    // Pop of rd=6 and push of rd=10 in the same cycle
    bus.mc_rd = 5'd10; bus.mc_data = 32'h0000A0A0;
    tick();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd6 || bus.rf_wdata !== 32'h600D)
      $display("FAIL mc_first: got we=%b rd=%0d data=%h want we=1 rd=6 data=0000600d", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    else passed++;
    checks++; if (bus.mc_ready !== 1'b1) $display("FAIL mc_pushpop_ready: got %b want 1", bus.mc_ready); else passed++;
    idle();
    tick();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd10 || bus.rf_wdata !== 32'hA0A0)
      $display("FAIL mc_second: got we=%b rd=%0d data=%h want we=1 rd=10 data=0000a0a0", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    else passed++;
    tick();
    checks++; if (bus.rf_we !== 1'b0) $display("FAIL mc_drained_we: got %b want 0", bus.rf_we); else passed++;
  endtask

  task automatic test_starvation();
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h100;
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd7; bus.mc_data = 32'h7777;
    tick();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd1) $display("FAIL starve_alu0: got we=%b rd=%0d want we=1 rd=1", bus.rf_we, bus.rf_waddr); else passed++;
    checks++; if (bus.mc_ready !== 1'b1) $display("FAIL starve_ready1: got %b want 1", bus.mc_ready); else passed++;
    bus.alu_data = 32'h101; bus.mc_rd = 5'd8; bus.mc_data = 32'h8888;
    tick();
    checks++; if (bus.mc_ready !== 1'b0) $display("FAIL starve_full_ready: got %b want 0", bus.mc_ready); else passed++;
    bus.mc_valid = 1'b0;
    tick();
    tick();
    checks++; if (bus.alu_stall !== 1'b0) $display("FAIL starve_no_stall_yet: got %b want 0", bus.alu_stall); else passed++;
    tick();
    checks++; if (bus.alu_stall !== 1'b1) $display("FAIL starve_stall: got %b want 1", bus.alu_stall); else passed++;
    checks++; if (bus.rf_waddr !== 5'd1) $display("FAIL starve_alu_last: got %0d want 1", bus.rf_waddr); else passed++;
    // Drain cycle: honour the stall; mc_valid on a full FIFO must not be accepted
    bus.alu_valid = 1'b0;
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd20; bus.mc_data = 32'h2020;
    tick();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd7 || bus.rf_wdata !== 32'h7777)
      $display("FAIL starve_drain7: got we=%b rd=%0d data=%h want we=1 rd=7 data=00007777", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    else passed++;
    checks++; if (bus.alu_stall !== 1'b0) $display("FAIL starve_stall_one_cycle: got %b want 0", bus.alu_stall); else passed++;
    checks++; if (bus.mc_ready !== 1'b1) $display("FAIL starve_ready_back: got %b want 1", bus.mc_ready); else passed++;
    idle();
    tick();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd8 || bus.rf_wdata !== 32'h8888)
      $display("FAIL starve_then8: got we=%b rd=%0d data=%h want we=1 rd=8 data=00008888", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    else passed++;
    tick();
    checks++; if (bus.rf_we !== 1'b0) $display("FAIL starve_no_rd20: got we=%b rd=%0d want we=0", bus.rf_we, bus.rf_waddr); else passed++;
    checks++; if (bus.proto_err !== 1'b0) $display("FAIL starve_proto_clean: got %b want 0", bus.proto_err); else passed++;
  endtask

  task automatic test_proto_err();
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'h200;
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd13; bus.mc_data = 32'h1313;
    tick();
    bus.mc_rd = 5'd14; bus.mc_data = 32'h1414;
    tick();
    bus.mc_valid = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (bus.alu_stall !== 1'b1) $display("FAIL proto_stall: got %b want 1", bus.alu_stall); else passed++;
    bus.alu_rd = 5'd3; bus.alu_data = 32'h333;
    tick();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd13 || bus.rf_wdata !== 32'h1313)
      $display("FAIL proto_head: got we=%b rd=%0d data=%h want we=1 rd=13 data=00001313", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    else passed++;
    checks++; if (bus.proto_err !== 1'b1) $display("FAIL proto_set: got %b want 1", bus.proto_err); else passed++;
    bus.alu_valid = 1'b0;
    tick();
    checks++; if (bus.rf_waddr !== 5'd14 || bus.rf_wdata !== 32'h1414)
      $display("FAIL proto_next: got rd=%0d data=%h want rd=14 data=00001414", bus.rf_waddr, bus.rf_wdata);
    else passed++;
    tick();
    checks++; if (bus.rf_we !== 1'b0) $display("FAIL proto_rd3_dropped: got we=%b rd=%0d want we=0", bus.rf_we, bus.rf_waddr); else passed++;
    tick();
    tick();
    checks++; if (bus.proto_err !== 1'b1) $display("FAIL proto_sticky: got %b want 1", bus.proto_err); else passed++;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.proto_err !== 1'b0) $display("FAIL proto_reset: got %b want 0", bus.proto_err); else passed++;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_midstream();
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h444;
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd11; bus.mc_data = 32'hB0B0;
    tick();
    bus.mc_rd = 5'd12; bus.mc_data = 32'hC0C0;
    tick();
    checks++; if (bus.mc_ready !== 1'b0) $display("FAIL mid_full: got %b want 0", bus.mc_ready); else passed++;
    checks++; if (bus.rf_we !== 1'b1) $display("FAIL mid_pending_we: got %b want 1", bus.rf_we); else passed++;
    bus.mc_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 32'd0)
      $display("FAIL mid_rst_rf: got we=%b rd=%0d data=%h want all 0", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    else passed++;
    checks++; if (bus.mc_ready !== 1'b0 || bus.alu_stall !== 1'b0 || bus.proto_err !== 1'b0)
      $display("FAIL mid_rst_ctl: got ready=%b stall=%b perr=%b want 0 0 0", bus.mc_ready, bus.alu_stall, bus.proto_err);
    else passed++;
    idle();
    tick();
    reset_n = 1'b1;
    tick();
    checks++; if (bus.mc_ready !== 1'b1) $display("FAIL mid_ready_release: got %b want 1", bus.mc_ready); else passed++;
    tick();
    checks++; if (bus.rf_we !== 1'b0) $display("FAIL mid_fifo_empty: got we=%b rd=%0d want we=0", bus.rf_we, bus.rf_waddr); else passed++;
    tick();
    checks++; if (bus.rf_we !== 1'b0) $display("FAIL mid_fifo_empty2: got we=%b rd=%0d want we=0", bus.rf_we, bus.rf_waddr); else passed++;
  endtask

  task automatic test_scoreboard();
    idle();
    bus.chk_rs1 = 5'd9;
    #1;
    checks++; if (bus.hazard !== 1'b0) $display("FAIL sb_clear: got %b want 0", bus.hazard); else passed++;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    tick();
    checks++; if (bus.hazard !== SbEn) $display("FAIL sb_issue: got %b want %b", bus.hazard, SbEn); else passed++;
    bus.issue_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h99;
    tick();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd9) $display("FAIL sb_wb: got we=%b rd=%0d want we=1 rd=9", bus.rf_we, bus.rf_waddr); else passed++;
    checks++; if (bus.hazard !== SbEn) $display("FAIL sb_wb_cycle: got %b want %b", bus.hazard, SbEn); else passed++;
    bus.alu_valid = 1'b0;
    tick();
    checks++; if (bus.hazard !== 1'b0) $display("FAIL sb_after_wb: got %b want 0", bus.hazard); else passed++;
    bus.alu_valid = 1'b1;
    tick();
    // Re-issue rd=9 while its writeback is on the port
    bus.alu_valid = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    tick();
    checks++; if (bus.hazard !== SbEn) $display("FAIL sb_set_wins: got %b want %b", bus.hazard, SbEn); else passed++;
    bus.issue_valid = 1'b0;
    tick();
    checks++; if (bus.hazard !== SbEn) $display("FAIL sb_held: got %b want %b", bus.hazard, SbEn); else passed++;
    bus.chk_rs1 = 5'd0;
    #1;
    checks++; if (bus.hazard !== 1'b0) $display("FAIL sb_rs1_zero: got %b want 0", bus.hazard); else passed++;
    bus.chk_rs2 = 5'd9;
    #1;
    checks++; if (bus.hazard !== SbEn) $display("FAIL sb_rs2: got %b want %b", bus.hazard, SbEn); else passed++;
    bus.chk_rs2 = 5'd0;
    #1;
    checks++; if (bus.hazard !== 1'b0) $display("FAIL sb_rs2_zero: got %b want 0", bus.hazard); else passed++;
  endtask

  initial begin
    test_reset();
    test_alu_single();
    test_mc_path();
    test_starvation();
    test_proto_err();
    test_reset_midstream();
    test_scoreboard();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
